dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single DRAM model port (one read channel, one write channel) between NUM_REQ lenet layer engines (conv, relu, pool).
- Independent round-robin arbitration on the read and write channels.
- Each accepted read is tagged with its requester ID in an in-order ID FIFO, so each dram_valid/data pair is routed back to the requester that issued it.
- Sits between the lenet layer engines and the dram instance.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = conv, 1 = relu, 2 = pool.
- DATA_WIDTH, 32, DRAM data width.
- ADDR_WIDTH, 18, DRAM word-address width.
- MAX_OUTSTANDING, 4, ID FIFO depth; maximum reads in flight (power of 2).

Ports:
- clk  input  1  clock; all state updates on posedge.
- srstn  input  1  asynchronous active-low reset.
- req_rd  input  NUM_REQ  per-requester read request.
- req_addr_rd  input  NUM_REQ*ADDR_WIDTH  read addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- gnt_rd  output  NUM_REQ  combinational read grant, one-hot or zero.
- rsp_valid  output  NUM_REQ  read-data-valid pulse routed to the issuing requester.
- rsp_data  output  DATA_WIDTH  read data, broadcast to all requesters.
- req_wr  input  NUM_REQ  per-requester write request.
- req_addr_wr  input  NUM_REQ*ADDR_WIDTH  write addresses, same packing as req_addr_rd.
- req_data_wr  input  NUM_REQ*DATA_WIDTH  write data, same packing.
- gnt_wr  output  NUM_REQ  combinational write grant, one-hot or zero.
- dram_en_rd, dram_addr_rd  output  1, ADDR_WIDTH  to dram read port.
- dram_valid, dram_data_rd  input  1, DATA_WIDTH  from dram read port.
- dram_en_wr, dram_addr_wr, dram_data_wr  output  1, ADDR_WIDTH, DATA_WIDTH  to dram write port.
- outstanding  output  clog2(MAX_OUTSTANDING)+1  current count of reads in flight.
- err_unexpected  output  1  sticky flag: dram_valid seen with no read outstanding.

Behaviour:
- Reset (async, srstn=0):
  - all dram_* outputs, rsp_valid, err_unexpected and outstanding go to 0;
  - both round-robin pointers go to 0;
  - ID FIFO is emptied.
- Handshake, both channels: a transfer occurs at a posedge where req[i] & gnt[i] = 1.
  - Requesters hold req and their address/data stable until granted.
  - A requester may keep req high after a grant to issue back-to-back transfers, one per cycle.
- Read arbitration:
  - gnt_rd = 0 whenever outstanding == MAX_OUTSTANDING. There is no bypass, even if dram_valid pops an entry in the same cycle.
  - Otherwise the grant goes to the first asserted req_rd searching from rd_ptr upward with wrap-around (rd_ptr, rd_ptr+1, ..., NUM_REQ-1, 0, ...).
  - On a transfer, rd_ptr <= winner+1, wrapping NUM_REQ-1 to 0. With no transfer, rd_ptr holds.
- Read issue: in the cycle after a transfer, dram_en_rd=1 and dram_addr_rd = the granted address, both registered. Otherwise dram_en_rd=0 and dram_addr_rd holds its last value.
- ID FIFO:
  - Pushes the winner ID on each read transfer; pops on dram_valid.
  - Push and pop in the same cycle: outstanding is unchanged and FIFO contents stay correct.
  - Response order is assumed in-order from dram.
- Response routing:
  - On dram_valid with outstanding>0: in the next cycle, rsp_valid[head ID]=1 for one cycle and rsp_data = registered dram_data_rd.
  - This gives a fixed 1-cycle response latency after dram_valid.
- Unexpected response: dram_valid with outstanding==0 sets err_unexpected (stays set until reset); no rsp_valid is produced and the FIFO is unchanged.
- Write arbitration:
  - Same round-robin scheme with its own wr_ptr; the write channel never stalls.
  - The cycle after a transfer: dram_en_wr=1, with dram_addr_wr/dram_data_wr registered from the winner. Otherwise dram_en_wr=0.
  - Reads and writes in the same cycle are independent; ordering between channels is the requesters' responsibility.
- Reset mid-operation: in-flight responses are discarded. A dram_valid arriving after reset sets err_unexpected.
- outstanding never exceeds MAX_OUTSTANDING and never underflows.

Decomposition:
- Shared package lenet_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH constants;
  - requester index constants REQ_CONV=0, REQ_RELU=1, REQ_POOL=2;
  - clog2 function.
- One sub-module, rr_arbiter (parameter N; inputs req, ptr; outputs one-hot gnt and winner index). It is instantiated twice, once for read and once for write.
- The ID FIFO is inline in dram_arbiter.

Test Plan:
- Single read: req_rd=001, addr 0x00010; dram returns 0xDEADBEEF after 3 cycles -> dram_en_rd with addr 0x00010 the cycle after grant; rsp_valid=001 with rsp_data 0xDEADBEEF one cycle after dram_valid.
- Round-robin fairness: req_rd=111 held for 6 transfers, rd_ptr starting at 0 -> grant order 0,1,2,0,1,2.
- Response routing: grants to 2,0,1 with dram_valid spaced 2 cycles apart -> rsp_valid 100, 001, 010 in that order.
- Backpressure: 4 reads in flight with no dram_valid -> gnt_rd=000 and outstanding=4. One dram_valid -> outstanding=3 and a grant resumes the following cycle.
- Writes alongside reads: req_wr=110 together with a read stream -> writes to requesters 1 then 2 appear on dram_en_wr on consecutive cycles; the read stream is unaffected.
- Error and reset: dram_valid with outstanding=0 -> err_unexpected=1 and no rsp_valid. srstn pulsed low mid-stream -> all outputs 0, outstanding=0 and err_unexpected cleared.

Source files
------------

// File: rtl/lenet_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | lenet_pkg : shared constants and helpers for the lenet DRAM subsystem
// | Rev 1.0   : initial release
// +-----------------------------------------------------------------------------
package lenet_pkg;

    localparam int LENET_DATA_WIDTH = 32;
    localparam int LENET_ADDR_WIDTH = 18;

    localparam int REQ_CONV = 0;
    localparam int REQ_RELU = 1;
    localparam int REQ_POOL = 2;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | rr_arbiter : combinational round-robin picker, search starts at ptr
// | Rev 1.0    : initial release
// +-----------------------------------------------------------------------------
module rr_arbiter
    import lenet_pkg::*;
#(
    parameter int N = 3,
    localparam int PW = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] winner
);

    int   w_idx;
    logic w_found;

    always_comb begin
        gnt     = '0;
        winner  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                winner     = PW'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | dram_arbiter : shares one DRAM read/write port among lenet layer engines
// | Rev 1.0      : initial release
// +-----------------------------------------------------------------------------
module dram_arbiter
    import lenet_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int DATA_WIDTH      = LENET_DATA_WIDTH,
    parameter int ADDR_WIDTH      = LENET_ADDR_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          srstn,
    input  logic [NUM_REQ-1:0]            req_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_rd,
    output logic [NUM_REQ-1:0]            gnt_rd,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_wr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_wr,
    output logic [NUM_REQ-1:0]            gnt_wr,
    output logic                          dram_en_rd,
    output logic [ADDR_WIDTH-1:0]         dram_addr_rd,
    input  logic                          dram_valid,
    input  logic [DATA_WIDTH-1:0]         dram_data_rd,
    output logic                          dram_en_wr,
    output logic [ADDR_WIDTH-1:0]         dram_addr_wr,
    output logic [DATA_WIDTH-1:0]         dram_data_wr,
    output logic [clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                          err_unexpected
);

    localparam int c_PW = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
    localparam int c_CW = clog2(MAX_OUTSTANDING) + 1;
    localparam int c_FW = (MAX_OUTSTANDING > 1) ? clog2(MAX_OUTSTANDING) : 1;

    logic [c_PW-1:0]       r_rd_ptr, r_wr_ptr;
    logic [c_PW-1:0]       w_rd_winner, w_wr_winner;
    logic [NUM_REQ-1:0]    w_rd_req;
    logic                  w_rd_stall, w_push, w_pop, w_wr_xfer;
    logic [ADDR_WIDTH-1:0] w_rd_addr, w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [NUM_REQ-1:0]    w_head_onehot;

    logic [c_CW-1:0]       r_outstanding;
    logic [c_FW-1:0]       r_fifo_wr, r_fifo_rd;
    logic [c_PW-1:0]       r_id_mem [MAX_OUTSTANDING];

    // No bypass: a full FIFO blocks grants even when a pop coincides.
    assign w_rd_stall = (r_outstanding == c_CW'(MAX_OUTSTANDING));
    assign w_rd_req   = w_rd_stall ? '0 : req_rd;
    assign w_push     = |gnt_rd;
    assign w_pop      = dram_valid && (r_outstanding != '0);
    assign w_wr_xfer  = |gnt_wr;

    rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
        .req    (w_rd_req),
        .ptr    (r_rd_ptr),
        .gnt    (gnt_rd),
        .winner (w_rd_winner)
    );

    rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
        .req    (req_wr),
        .ptr    (r_wr_ptr),
        .gnt    (gnt_wr),
        .winner (w_wr_winner)
    );

    always_comb begin
        w_rd_addr     = '0;
        w_wr_addr     = '0;
        w_wr_data     = '0;
        w_head_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_rd[i]) w_rd_addr = w_rd_addr | req_addr_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (gnt_wr[i]) begin
                w_wr_addr = w_wr_addr | req_addr_wr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wr_data = w_wr_data | req_data_wr[i*DATA_WIDTH +: DATA_WIDTH];
            end
            w_head_onehot[i] = (r_id_mem[r_fifo_rd] == c_PW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_id_mem[r_fifo_wr] <= w_rd_winner;
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_outstanding  <= '0;
            r_fifo_wr      <= '0;
            r_fifo_rd      <= '0;
            dram_en_rd     <= 1'b0;
            dram_addr_rd   <= '0;
            dram_en_wr     <= 1'b0;
            dram_addr_wr   <= '0;
            dram_data_wr   <= '0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            err_unexpected <= 1'b0;
        end else begin
            dram_en_rd <= w_push;
            dram_en_wr <= w_wr_xfer;
            rsp_valid  <= w_pop ? w_head_onehot : '0;
            if (w_push) begin
                r_rd_ptr     <= (w_rd_winner == c_PW'(NUM_REQ - 1)) ? '0 : w_rd_winner + 1'b1;
                dram_addr_rd <= w_rd_addr;
                r_fifo_wr    <= r_fifo_wr + 1'b1;
            end
            if (w_wr_xfer) begin
                r_wr_ptr     <= (w_wr_winner == c_PW'(NUM_REQ - 1)) ? '0 : w_wr_winner + 1'b1;
                dram_addr_wr <= w_wr_addr;
                dram_data_wr <= w_wr_data;
            end
            if (w_pop) begin
                rsp_data  <= dram_data_rd;
                r_fifo_rd <= r_fifo_rd + 1'b1;
            end
            if (dram_valid && !w_pop) begin
                err_unexpected <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign outstanding = r_outstanding;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_dram_arbiter : directed self-checking bench for dram_arbiter
// | Rev 1.0         : initial release
// +-----------------------------------------------------------------------------
module tb_dram_arbiter;

    localparam int NR = 3;
    localparam int DW = 32;
    localparam int AW = 18;

    logic          clk, srstn;
    logic [NR-1:0] req_rd, gnt_rd, rsp_valid, req_wr, gnt_wr;
    logic [NR*AW-1:0] req_addr_rd, req_addr_wr;
    logic [NR*DW-1:0] req_data_wr;
    logic [DW-1:0] rsp_data, dram_data_rd, dram_data_wr;
    logic          dram_en_rd, dram_valid, dram_en_wr, err_unexpected;
    logic [AW-1:0] dram_addr_rd, dram_addr_wr;
    logic [2:0]    outstanding;

    int vectors = 0;
    int miscompares = 0;

    dram_arbiter u_dut (
        .clk            (clk),
        .srstn          (srstn),
        .req_rd         (req_rd),
        .req_addr_rd    (req_addr_rd),
        .gnt_rd         (gnt_rd),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .req_wr         (req_wr),
        .req_addr_wr    (req_addr_wr),
        .req_data_wr    (req_data_wr),
        .gnt_wr         (gnt_wr),
        .dram_en_rd     (dram_en_rd),
        .dram_addr_rd   (dram_addr_rd),
        .dram_valid     (dram_valid),
        .dram_data_rd   (dram_data_rd),
        .dram_en_wr     (dram_en_wr),
        .dram_addr_wr   (dram_addr_wr),
        .dram_data_wr   (dram_data_wr),
        .outstanding    (outstanding),
        .err_unexpected (err_unexpected)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        srstn = 1'b0;
        step();
        srstn = 1'b1;
        step();
    endtask

    initial begin
        logic [2:0] exp_route [3];
        logic [2:0] exp_bp [4];
        logic [2:0] exp_drain [4];
        exp_route = '{3'b100, 3'b001, 3'b010};
        exp_bp    = '{3'b100, 3'b001, 3'b010, 3'b100};
        exp_drain = '{3'b001, 3'b010, 3'b100, 3'b001};

        clk = 1'b0; srstn = 1'b0;
        req_rd = '0; req_wr = '0; req_addr_rd = '0; req_addr_wr = '0; req_data_wr = '0;
        dram_valid = 1'b0; dram_data_rd = '0;
        step(); step();

        // reset state
        chk("rst_en_rd", dram_en_rd, 0);
        chk("rst_en_wr", dram_en_wr, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_unexpected, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        srstn = 1'b1;
        step();

        // single read
        req_addr_rd[0 +: AW] = 18'h00010;
        req_rd = 3'b001;
        #1 chk("single_gnt", gnt_rd, 3'b001);
        step();
        req_rd = 3'b000;
        chk("single_en_rd", dram_en_rd, 1);
        chk("single_addr", dram_addr_rd, 18'h00010);
        chk("single_outst", outstanding, 1);
        step();
        chk("single_en_rd_low", dram_en_rd, 0);
        chk("single_addr_hold", dram_addr_rd, 18'h00010);
        step();
        dram_valid = 1'b1; dram_data_rd = 32'hDEADBEEF;
        step();
        dram_valid = 1'b0;
        chk("single_rsp_valid", rsp_valid, 3'b001);
        chk("single_rsp_data", rsp_data, 32'hDEADBEEF);
        chk("single_outst_0", outstanding, 0);
        step();
        chk("single_rsp_pulse", rsp_valid, 0);

        // round-robin fairness from pointer 0, one response per cycle after the first
        do_reset();
        for (int i = 0; i < NR; i++) req_addr_rd[i*AW +: AW] = 18'h100 + 18'(i);
        req_rd = 3'b111;
        for (int k = 0; k < 6; k++) begin
            dram_valid   = (k >= 1);
            dram_data_rd = 32'hA000 + 32'(k);
            #1 chk("rr_gnt", gnt_rd, 3'b001 << (k % 3));
            step();
            chk("rr_addr", dram_addr_rd, 18'h100 + 18'(k % 3));
            if (k >= 1) chk("rr_rsp", rsp_valid, 3'b001 << ((k - 1) % 3));
        end
        req_rd = 3'b000;
        dram_data_rd = 32'hA006;
        step();
        dram_valid = 1'b0;
        chk("rr_last_rsp", rsp_valid, 3'b100);
        chk("rr_last_data", rsp_data, 32'hA006);
        chk("rr_outst", outstanding, 0);

        // response routing: grants 2,0,1 then responses 2 cycles apart
        req_rd = 3'b100;
        #1 chk("route_gnt2", gnt_rd, 3'b100);
        step();
        req_rd = 3'b001;
        #1 chk("route_gnt0", gnt_rd, 3'b001);
        step();
        req_rd = 3'b010;
        #1 chk("route_gnt1", gnt_rd, 3'b010);
        step();
        req_rd = 3'b000;
        chk("route_outst", outstanding, 3);
        for (int j = 0; j < 3; j++) begin
            dram_valid = 1'b1;
            dram_data_rd = 32'hB000 + 32'(j);
            step();
            dram_valid = 1'b0;
            chk("route_rsp", rsp_valid, exp_route[j]);
            chk("route_data", rsp_data, 32'hB000 + 32'(j));
            step();
        end
        chk("route_outst_0", outstanding, 0);

        // backpressure: pointer is at 2 here
        req_rd = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1 chk("bp_gnt", gnt_rd, exp_bp[k]);
            step();
        end
        #1 chk("bp_full_gnt", gnt_rd, 3'b000);
        chk("bp_full_outst", outstanding, 4);
        dram_valid = 1'b1; dram_data_rd = 32'hC0;
        #1 chk("bp_no_bypass", gnt_rd, 3'b000);
        step();
        dram_valid = 1'b0;
        chk("bp_outst_3", outstanding, 3);
        chk("bp_rsp", rsp_valid, 3'b100);
        #1 chk("bp_resume_gnt", gnt_rd, 3'b001);
        step();
        req_rd = 3'b000;
        chk("bp_outst_4", outstanding, 4);
        dram_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("bp_drain_rsp", rsp_valid, exp_drain[j]);
        end
        dram_valid = 1'b0;
        chk("bp_drain_outst", outstanding, 0);

        // writes alongside reads (read pointer is at 1, write pointer at 0)
        for (int i = 0; i < NR; i++) begin
            req_addr_wr[i*AW +: AW] = 18'h200 + 18'(i);
            req_data_wr[i*DW +: DW] = 32'h5000_0000 + 32'(i);
        end
        req_addr_rd[0 +: AW] = 18'h300;
        req_wr = 3'b110;
        req_rd = 3'b001;
        #1 chk("wr_gnt1", gnt_wr, 3'b010);
        chk("wr_rd_gnt_a", gnt_rd, 3'b001);
        step();
        req_wr = 3'b100;
        chk("wr_en_a", dram_en_wr, 1);
        chk("wr_addr_a", dram_addr_wr, 18'h201);
        chk("wr_data_a", dram_data_wr, 32'h5000_0001);
        chk("wr_rd_en_a", dram_en_rd, 1);
        chk("wr_rd_addr_a", dram_addr_rd, 18'h300);
        #1 chk("wr_gnt2", gnt_wr, 3'b100);
        chk("wr_rd_gnt_b", gnt_rd, 3'b001);
        step();
        req_wr = 3'b000;
        req_rd = 3'b000;
        chk("wr_en_b", dram_en_wr, 1);
        chk("wr_addr_b", dram_addr_wr, 18'h202);
        chk("wr_data_b", dram_data_wr, 32'h5000_0002);
        chk("wr_rd_en_b", dram_en_rd, 1);
        chk("wr_rd_outst", outstanding, 2);
        step();
        chk("wr_en_idle", dram_en_wr, 0);
        chk("wr_rd_en_idle", dram_en_rd, 0);
        dram_valid = 1'b1;
        step();
        chk("wr_rd_rsp_a", rsp_valid, 3'b001);
        step();
        dram_valid = 1'b0;
        chk("wr_rd_rsp_b", rsp_valid, 3'b001);
        chk("wr_rd_outst_0", outstanding, 0);

        // unexpected response
        chk("err_before", err_unexpected, 0);
        dram_valid = 1'b1;
        step();
        dram_valid = 1'b0;
        chk("err_set", err_unexpected, 1);
        chk("err_no_rsp", rsp_valid, 0);
        chk("err_outst", outstanding, 0);
        step();
        chk("err_sticky", err_unexpected, 1);

        // reset mid-stream
        req_rd = 3'b001;
        step();
        step();
        chk("mid_outst", outstanding, 2);
        req_rd = 3'b000;
        srstn = 1'b0;
        #1;
        chk("mid_rst_en_rd", dram_en_rd, 0);
        chk("mid_rst_addr_rd", dram_addr_rd, 0);
        chk("mid_rst_outst", outstanding, 0);
        chk("mid_rst_err", err_unexpected, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        chk("mid_rst_en_wr", dram_en_wr, 0);
        chk("mid_rst_addr_wr", dram_addr_wr, 0);
        chk("mid_rst_data_wr", dram_data_wr, 0);
        step();
        srstn = 1'b1;
        step();
        dram_valid = 1'b1;
        step();
        dram_valid = 1'b0;
        chk("post_rst_err", err_unexpected, 1);
        chk("post_rst_no_rsp", rsp_valid, 0);
        chk("post_rst_outst", outstanding, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
